// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Shared console serial transmitter. Two byte requesters (port 0: CPU console,
// port 1: debug monitor) compete for a single tx line. A round-robin arbiter
// picks the winner in IDLE, latches its byte and pulses its ack, then the
// frame is serialised LSB first using ticks recovered from the baud square
// wave.
//
// Parameters:
//   DATA_BITS  data bits per frame (5..8)
//   STOP_BITS  stop bits per frame (1 or 2)
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   tx_baud_clk  baud square wave, one full period per bit time
//   req0/data0   port 0 request and byte, held until ack0
//   ack0         one-cycle pulse when data0 is latched
//   req1/data1   port 1 request and byte, held until ack1
//   ack1         one-cycle pulse when data1 is latched
//   busy         high from grant until the end of the last stop bit
//   gnt_id       port that owns the current or most recent frame
//   tx           serial output, idle high, driven straight from a flop
//
// Build option:
//   UART_TX_PARITY_EN  when defined, an even parity bit is sent between the
//                      last data bit and the first stop bit.

module uart_tx_arb #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tx_baud_clk,
  input  logic                 req0,
  input  logic [DATA_BITS-1:0] data0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack1,
  output logic                 busy,
  output logic                 gnt_id,
  output logic                 tx
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t               state, state_n;
  logic                 baud_q1, baud_q2;
  logic                 tick;
  logic                 rr_ptr, rr_ptr_n;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_n;
  logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
  logic                 stop_cnt, stop_cnt_n;
  logic                 tx_n, ack0_n, ack1_n, busy_n, gnt_id_n;
  logic                 pick;
  logic [DATA_BITS-1:0] pick_data;
`ifdef UART_TX_PARITY_EN
  logic                 parity_bit, parity_bit_n;
`endif

  // Two-flop capture of the baud square wave; a tick is its rising edge,
  // so exactly one tick arrives per bit time.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_q1 <= 1'b0;
      baud_q2 <= 1'b0;
    end else begin
      baud_q1 <= tx_baud_clk;
      baud_q2 <= baud_q1;
    end
  end

  assign tick = baud_q1 & ~baud_q2;

  // With both ports requesting, the pointer names the port that did not win
  // last time; a lone requester wins regardless of the pointer.
  assign pick      = (req0 & req1) ? rr_ptr : req1;
  assign pick_data = pick ? data1 : data0;

  // State and datapath registers. tx and the acks come straight from flops
  // so the pin never sees combinational glitches.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx         <= 1'b1;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      busy       <= 1'b0;
      gnt_id     <= 1'b0;
      rr_ptr     <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      tx         <= tx_n;
      ack0       <= ack0_n;
      ack1       <= ack1_n;
      busy       <= busy_n;
      gnt_id     <= gnt_id_n;
      rr_ptr     <= rr_ptr_n;
      shift_reg  <= shift_reg_n;
      bit_cnt    <= bit_cnt_n;
      stop_cnt   <= stop_cnt_n;
`ifdef UART_TX_PARITY_EN
      parity_bit <= parity_bit_n;
`endif
    end
  end

  // Next-state logic. Everything except the grant in IDLE advances only on
  // a tick; SYNC is entered on the grant edge, so the tick it waits for is
  // always one that arrives strictly after the grant.
  always_comb begin
    state_n      = state;
    tx_n         = tx;
    ack0_n       = 1'b0;
    ack1_n       = 1'b0;
    busy_n       = busy;
    gnt_id_n     = gnt_id;
    rr_ptr_n     = rr_ptr;
    shift_reg_n  = shift_reg;
    bit_cnt_n    = bit_cnt;
    stop_cnt_n   = stop_cnt;
`ifdef UART_TX_PARITY_EN
    parity_bit_n = parity_bit;
`endif

    unique case (state)
      IDLE: begin
        if (req0 | req1) begin
          shift_reg_n  = pick_data;
          ack0_n       = ~pick;
          ack1_n       = pick;
          gnt_id_n     = pick;
          rr_ptr_n     = ~pick;
          busy_n       = 1'b1;
          bit_cnt_n    = '0;
          stop_cnt_n   = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_bit_n = ^pick_data;
`endif
          state_n      = SYNC;
        end
      end

      SYNC: begin
        if (tick) begin
          tx_n    = 1'b0;
          state_n = START;
        end
      end

      START: begin
        if (tick) begin
          tx_n      = shift_reg[0];
          bit_cnt_n = '0;
          state_n   = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          shift_reg_n = shift_reg >> 1;
          bit_cnt_n   = bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            tx_n    = parity_bit;
            state_n = PARITY;
`else
            tx_n       = 1'b1;
            stop_cnt_n = 1'b0;
            state_n    = STOP;
`endif
          end else begin
            tx_n = shift_reg[1];
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          tx_n       = 1'b1;
          stop_cnt_n = 1'b0;
          state_n    = STOP;
        end
      end
`endif

      STOP: begin
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            stop_cnt_n = stop_cnt + 1'b1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule
